// File: rtl/spi_shift_engine.sv
// spi_shift_engine
//   Serial datapath stage behind the SPI control block. Holds one TX byte and
//   one RX byte, generates SCLK (mode 0: CPOL=0, CPHA=0), shifts MOSI out and
//   MISO in. Reports holding-register full/empty states back to the control
//   block.
//
//   Build option: define SPI_SHIFT_LSB_FIRST_EN for LSB-first shifting.
//   Timing, flags and latency are the same in both builds.
//
// Ports
//   CLK                  system clock, rising edge
//   CLR_N                asynchronous active-low reset
//   TE / RE              transmit / receive enable
//   SENDER_WRITE         pulse: load TX_DATA into the TX holding register
//   TX_DATA              byte to send
//   SENDER_FULL_STATE    TX holding register occupied
//   SENDER_EMPTY_STATE   ~SENDER_FULL_STATE
//   RECEIVER_READ        pulse: pop the RX holding register
//   RX_DATA              RX holding register contents
//   RECEIVER_FULL_STATE  RX holding register occupied
//   RECEIVER_EMPTY_STATE ~RECEIVER_FULL_STATE
//   OVERRUN              sticky: a received byte was lost (RX still full)
//   BUSY                 transfer in progress (state != IDLE)
//   SCLK / MOSI / MISO   serial interface
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a start condition
// LEAD  | SCLK low, first MOSI bit set up, CLK_DIV cycles
// SHIFT | 2*DATA_W SCLK half-periods; sample on rise, shift on fall
// TRAIL | SCLK low hold, CLK_DIV cycles
// DONE  | one cycle: move RX shift into the holding register (if RE)
module spi_shift_engine #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic              TE,
  input  logic              RE,
  input  logic              SENDER_WRITE,
  input  logic [DATA_W-1:0] TX_DATA,
  output logic              SENDER_FULL_STATE,
  output logic              SENDER_EMPTY_STATE,
  input  logic              RECEIVER_READ,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              RECEIVER_FULL_STATE,
  output logic              RECEIVER_EMPTY_STATE,
  output logic              OVERRUN,
  output logic              BUSY,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_TRAIL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              sclk_q;
  logic [DATA_W-1:0] tx_hold, tx_shift, rx_shift, rx_data_q;
  logic              tx_full, rx_full, overrun_q;

  logic div_expire, start_tx, start_rx, start;
  logic rise_tog, fall_tog, last_fall;
  logic write_ok, done_load, done_lost;

  always_comb begin
    div_expire = (div_cnt == '0);
    start_tx   = (state == S_IDLE) && TE && tx_full;
    start_rx   = (state == S_IDLE) && RE && !TE;
    start      = start_tx || start_rx;
    rise_tog   = (state == S_SHIFT) && div_expire && !sclk_q;
    fall_tog   = (state == S_SHIFT) && div_expire && sclk_q;
    last_fall  = fall_tog && (bit_cnt == '0);
    // A write landing on the cycle that empties the holding register is kept.
    write_ok   = SENDER_WRITE && (!tx_full || start_tx);
    // A read coinciding with DONE frees the slot for the new byte.
    done_load  = (state == S_DONE) && RE && (!rx_full || RECEIVER_READ);
    done_lost  = (state == S_DONE) && RE && rx_full && !RECEIVER_READ;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)      state_nxt = S_LEAD;
      S_LEAD:  if (div_expire) state_nxt = S_SHIFT;
      S_SHIFT: if (last_fall)  state_nxt = S_TRAIL;
      S_TRAIL: if (div_expire) state_nxt = S_DONE;
      S_DONE:                  state_nxt = S_IDLE;
      default:                 state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Half-period divider and bit counter
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk_q  <= 1'b0;
    end else begin
      if (start)
        div_cnt <= DIV_LOAD;
      else if (state == S_LEAD || state == S_SHIFT || state == S_TRAIL)
        div_cnt <= div_expire ? DIV_LOAD : div_cnt - DIV_W'(1);

      if (start)
        bit_cnt <= BIT_LOAD;
      else if (fall_tog && !last_fall)
        bit_cnt <= bit_cnt - BIT_W'(1);

      if (start)
        sclk_q <= 1'b0;
      else if (rise_tog || fall_tog)
        sclk_q <= ~sclk_q;
    end
  end

  // Shift registers. The TX register is not shifted on the final falling
  // toggle, so MOSI keeps the last data bit through TRAIL.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      tx_shift <= '0;
      rx_shift <= '0;
    end else begin
      if (start_tx)
        tx_shift <= tx_hold;
      else if (start_rx)
        tx_shift <= '1;
      else if (fall_tog && !last_fall)
`ifdef SPI_SHIFT_LSB_FIRST_EN
        tx_shift <= {1'b0, tx_shift[DATA_W-1:1]};
`else
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
`endif

      if (rise_tog)
`ifdef SPI_SHIFT_LSB_FIRST_EN
        rx_shift <= {MISO, rx_shift[DATA_W-1:1]};
`else
        rx_shift <= {rx_shift[DATA_W-2:0], MISO};
`endif
    end
  end

  // Holding registers and flags
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      tx_hold   <= '0;
      tx_full   <= 1'b0;
      rx_data_q <= '0;
      rx_full   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (write_ok) begin
        tx_hold <= TX_DATA;
        tx_full <= 1'b1;
      end else if (start_tx) begin
        tx_full <= 1'b0;
      end

      if (done_load) begin
        rx_data_q <= rx_shift;
        rx_full   <= 1'b1;
      end else if (RECEIVER_READ) begin
        rx_full <= 1'b0;
      end

      if (done_lost)
        overrun_q <= 1'b1;
    end
  end

  always_comb begin
    SENDER_FULL_STATE    = tx_full;
    SENDER_EMPTY_STATE   = ~tx_full;
    RX_DATA              = rx_data_q;
    RECEIVER_FULL_STATE  = rx_full;
    RECEIVER_EMPTY_STATE = ~rx_full;
    OVERRUN              = overrun_q;
    BUSY                 = (state != S_IDLE);
    SCLK                 = sclk_q;
`ifdef SPI_SHIFT_LSB_FIRST_EN
    MOSI                 = tx_shift[0];
`else
    MOSI                 = tx_shift[DATA_W-1];
`endif
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
`timescale 1ns/1ps
module tb_spi_shift_engine;
  localparam int W    = 8;
  localparam int CD   = 2;
  localparam int LAT  = (2*W+2)*CD+1;
  localparam int TCLK = 10;

  logic         CLK = 1'b0;
  logic         CLR_N = 1'b0;
  logic         TE = 1'b0;
  logic         RE = 1'b0;
  logic         SENDER_WRITE = 1'b0;
  logic [W-1:0] TX_DATA = '0;
  logic         SENDER_FULL_STATE, SENDER_EMPTY_STATE;
  logic         RECEIVER_READ = 1'b0;
  logic [W-1:0] RX_DATA;
  logic         RECEIVER_FULL_STATE, RECEIVER_EMPTY_STATE;
  logic         OVERRUN, BUSY, SCLK, MOSI, MISO;

  spi_shift_engine #(.DATA_W(W), .CLK_DIV(CD)) dut (
    .CLK                  (CLK),
    .CLR_N                (CLR_N),
    .TE                   (TE),
    .RE                   (RE),
    .SENDER_WRITE         (SENDER_WRITE),
    .TX_DATA              (TX_DATA),
    .SENDER_FULL_STATE    (SENDER_FULL_STATE),
    .SENDER_EMPTY_STATE   (SENDER_EMPTY_STATE),
    .RECEIVER_READ        (RECEIVER_READ),
    .RX_DATA              (RX_DATA),
    .RECEIVER_FULL_STATE  (RECEIVER_FULL_STATE),
    .RECEIVER_EMPTY_STATE (RECEIVER_EMPTY_STATE),
    .OVERRUN              (OVERRUN),
    .BUSY                 (BUSY),
    .SCLK                 (SCLK),
    .MOSI                 (MOSI),
    .MISO                 (MISO)
  );

  always #(TCLK/2) CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Serial-side observer: records MOSI at every SCLK rise and plays a MISO
  // pattern in transmission order (or loops MOSI back).
  logic         loop_en = 1'b0;
  logic [W-1:0] miso_pat = '0;
  int           rise_idx = 0;
  logic         sclk_prev = 1'b0;
  logic         mosi_bits[$];
  time          rise_t[$];
  time          busy_t0 = 0;

  function automatic logic pat_bit(input logic [W-1:0] p, input int idx);
    int k;
    k = (idx > W-1) ? W-1 : idx;
`ifdef SPI_SHIFT_LSB_FIRST_EN
    return p[k];
`else
    return p[W-1-k];
`endif
  endfunction

  assign MISO = loop_en ? MOSI : pat_bit(miso_pat, rise_idx);

  always @(negedge CLK) begin
    if (SCLK && !sclk_prev) begin
      mosi_bits.push_back(MOSI);
      rise_t.push_back($time);
      rise_idx = rise_idx + 1;
    end
    if (!BUSY) rise_idx = 0;
    sclk_prev = SCLK;
  end

  // Reassemble the observed serial bits into a byte in transmission order.
  function automatic logic [W-1:0] pack_bits();
    logic [W-1:0] v;
    v = '0;
    foreach (mosi_bits[i]) begin
`ifdef SPI_SHIFT_LSB_FIRST_EN
      v = {mosi_bits[i], v[W-1:1]};
`else
      v = {v[W-2:0], mosi_bits[i]};
`endif
    end
    return v;
  endfunction

  // Reference model of the holding-register side
  logic [W-1:0] m_rx = '0;
  logic         m_rx_full = 1'b0;
  logic         m_ovr = 1'b0;

  function automatic void model_done(input bit re, input bit rd, input logic [W-1:0] rx);
    if (re) begin
      if (m_rx_full && !rd) m_ovr = 1'b1;
      else begin
        m_rx      = rx;
        m_rx_full = 1'b1;
      end
    end else if (rd) begin
      m_rx_full = 1'b0;
    end
  endfunction

  task automatic check_flags(input string tag);
    check_eq({tag, ":rx_data"}, RX_DATA, m_rx);
    check_eq({tag, ":rx_full"}, RECEIVER_FULL_STATE, m_rx_full);
    check_eq({tag, ":rx_empty"}, RECEIVER_EMPTY_STATE, !m_rx_full);
    check_eq({tag, ":overrun"}, OVERRUN, m_ovr);
  endtask

  task automatic drive_write(input logic [W-1:0] d);
    TX_DATA      = d;
    SENDER_WRITE = 1'b1;
    @(negedge CLK);
    SENDER_WRITE = 1'b0;
  endtask

  task automatic pop_rx();
    RECEIVER_READ = 1'b1;
    @(negedge CLK);
    RECEIVER_READ = 1'b0;
    m_rx_full = 1'b0;
    check_eq("pop:rx_full", RECEIVER_FULL_STATE, 0);
  endtask

  task automatic wait_start();
    int guard;
    guard = 0;
    while (!BUSY && guard < 200) begin
      @(negedge CLK);
      guard++;
    end
    check_eq("xfer_start", guard < 200, 1);
    mosi_bits.delete();
    rise_t.delete();
    busy_t0 = $time;
  endtask

  // Returns at the first idle cycle; len is the number of BUSY cycles.
  task automatic wait_end(input bit rd_done, output int len);
    int guard;
    guard = 0;
    while (BUSY && guard < 400) begin
      RECEIVER_READ = rd_done && ((($time - busy_t0) / TCLK) == LAT-1);
      @(negedge CLK);
      guard++;
    end
    RECEIVER_READ = 1'b0;
    len = int'(($time - busy_t0) / TCLK);
  endtask

  task automatic check_xfer(input string tag, input logic [W-1:0] exp_tx, input int len);
    int  bad;
    time first;
    bad = 0;
    for (int i = 1; i < rise_t.size(); i++)
      if (rise_t[i] - rise_t[i-1] != 2*CD*TCLK) bad++;
    first = (rise_t.size() > 0) ? rise_t[0] - busy_t0 : 0;
    check_eq({tag, ":latency"}, len, LAT);
    check_eq({tag, ":pulses"}, mosi_bits.size(), W);
    check_eq({tag, ":mosi"}, pack_bits(), exp_tx);
    check_eq({tag, ":period"}, bad, 0);
    check_eq({tag, ":first_rise"}, 32'(first), 2*CD*TCLK);
  endtask

  task automatic run_xfer(input string tag, input bit te, input bit re, input bit lp,
                          input logic [W-1:0] tx, input logic [W-1:0] pat, input bit rd);
    int           len;
    logic [W-1:0] sent, exp_rx;
    loop_en  = lp;
    miso_pat = pat;
    TE       = te;
    RE       = re;
    if (te) drive_write(tx);
    wait_start();
    wait_end(rd, len);
    TE = 1'b0;
    RE = 1'b0;
    sent   = te ? tx : '1;
    exp_rx = lp ? sent : pat;
    check_xfer(tag, sent, len);
    model_done(re, rd, exp_rx);
    check_flags(tag);
    check_eq({tag, ":tx_empty"}, SENDER_EMPTY_STATE, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int  idle_bad, len, guard;
    time t_end1;

    // Reset and idle
    repeat (3) @(negedge CLK);
    check_eq("rst:sclk", SCLK, 0);
    check_eq("rst:busy", BUSY, 0);
    check_eq("rst:mosi", MOSI, 0);
    check_eq("rst:tx_full", SENDER_FULL_STATE, 0);
    check_flags("rst");
    CLR_N = 1'b1;
    idle_bad = 0;
    repeat (100) begin
      @(negedge CLK);
      if (SCLK || BUSY || !SENDER_EMPTY_STATE || !RECEIVER_EMPTY_STATE || OVERRUN) idle_bad++;
    end
    check_eq("idle_quiet", idle_bad, 0);

    // Directed transfers
    run_xfer("a5_loop", 1, 1, 1, 8'hA5, 8'h00, 0);
    pop_rx();
    run_xfer("rx_3c", 0, 1, 0, 8'h00, 8'h3C, 0);
    pop_rx();
    run_xfer("rx_11a", 0, 1, 0, 8'h00, 8'h11, 0);
    run_xfer("rx_22_read", 0, 1, 0, 8'h00, 8'h22, 1);
    pop_rx();
    run_xfer("rx_11b", 0, 1, 0, 8'h00, 8'h11, 0);
    run_xfer("rx_22_ovr", 0, 1, 0, 8'h00, 8'h22, 0);

    // Back-to-back: second write accepted during shift, third ignored
    loop_en = 1'b1;
    RE      = 1'b0;
    TE      = 1'b1;
    drive_write(8'h55);
    wait_start();
    repeat (6) @(negedge CLK);
    drive_write(8'h66);
    check_eq("b2b:accept", SENDER_FULL_STATE, 1);
    drive_write(8'h77);
    check_eq("b2b:full_kept", SENDER_FULL_STATE, 1);
    wait_end(0, len);
    t_end1 = $time;
    check_xfer("b2b_first", 8'h55, len);
    wait_start();
    check_eq("b2b:gap", 32'((busy_t0 - t_end1) / TCLK), 1);
    wait_end(0, len);
    TE = 1'b0;
    check_xfer("b2b_second", 8'h66, len);
    check_eq("b2b:drained", SENDER_EMPTY_STATE, 1);
    check_flags("b2b");

    // Randomized transfers against the model
    for (int n = 0; n < 10; n++) begin
      int           mode;
      logic [W-1:0] tx, pat;
      bit           rd;
      mode = $urandom_range(0, 2);
      tx   = W'($urandom);
      pat  = W'($urandom);
      rd   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) pop_rx();
      case (mode)
        0:       run_xfer("rand_loop", 1, 1, 1, tx, pat, rd);
        1:       run_xfer("rand_rx", 0, 1, 0, tx, pat, rd);
        default: run_xfer("rand_tx", 1, 0, 1'($urandom_range(0, 1)), tx, pat, rd);
      endcase
    end

    // Reset in the middle of a transfer
    loop_en = 1'b1;
    TE      = 1'b1;
    RE      = 1'b1;
    drive_write(8'hC3);
    wait_start();
    drive_write(8'h99);
    guard = 0;
    while (mosi_bits.size() < 4 && guard < 100) begin
      @(negedge CLK);
      #1;
      guard++;
    end
    check_eq("rst_mid:reached", guard < 100, 1);
    check_eq("rst_mid:pre_tx_full", SENDER_FULL_STATE, 1);
    CLR_N = 1'b0;
    #1;
    m_rx      = '0;
    m_rx_full = 1'b0;
    m_ovr     = 1'b0;
    check_eq("rst_mid:sclk", SCLK, 0);
    check_eq("rst_mid:busy", BUSY, 0);
    check_eq("rst_mid:mosi", MOSI, 0);
    check_eq("rst_mid:tx_full", SENDER_FULL_STATE, 0);
    check_flags("rst_mid");
    @(negedge CLK);
    CLR_N = 1'b1;
    @(negedge CLK);
    check_eq("rst_mid:stays_idle", BUSY, 0);
    run_xfer("post_rst_81", 1, 1, 1, 8'h81, 8'h00, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
